// File: rtl/float_pkg.sv
// Shared float-format helpers: field widths, bias and max-exponent derivation.
// Used by int_to_float, the float adder and other float units.
package float_pkg;

    localparam int unsigned E_BIT = 8;
    localparam int unsigned F_BIT = 23;

    function automatic int unsigned bias_of(input int unsigned e_bit);
        return (32'd1 << (e_bit - 1)) - 32'd1;
    endfunction

    function automatic int unsigned e_max_of(input int unsigned e_bit);
        return (32'd1 << e_bit) - 32'd1;
    endfunction

    function automatic int unsigned float_width(input int unsigned e_bit, input int unsigned f_bit);
        return 32'd1 + e_bit + f_bit;
    endfunction

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    localparam int unsigned BIAS  = bias_of(E_BIT);
    localparam int unsigned E_MAX = e_max_of(E_BIT);

endpackage

// File: rtl/lzc_prio.sv
// Parallel leading-zero counter; all-zero input yields W.
module lzc_prio #(
    parameter  int unsigned W  = 32,
    localparam int unsigned OW = $clog2(W + 1)
) (
    input  logic [W-1:0]  d,
    output logic [OW-1:0] lz_c
);

    // Scan upward so the highest set bit is the last (winning) assignment.
    always_comb begin
        lz_c = OW'(W);
        for (int unsigned i = 0; i < W; i++) begin
            if (d[i]) lz_c = OW'(W - 1 - i);
        end
    end

endmodule

// File: rtl/int_to_float.sv
// Three-stage integer to float converter: sign/magnitude, normalise, round/pack.
// Whole pipe advances together whenever the output register is empty or being drained.
module int_to_float
    import float_pkg::*;
#(
    parameter int unsigned E_bit = E_BIT,
    parameter int unsigned F_bit = F_BIT,
    parameter int unsigned I_bit = 32
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic [I_bit-1:0]                     int_in,
    input  logic                                 in_signed,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic [float_width(E_bit, F_bit)-1:0] float_out,
    output logic                                 inexact,
    output logic                                 overflow
);

    localparam int unsigned FW     = float_width(E_bit, F_bit);
    localparam int unsigned LZW    = $clog2(I_bit + 1);
    localparam int unsigned UW     = $clog2(I_bit);
    localparam int unsigned XW     = I_bit - 1 + F_bit + 2;
    localparam int unsigned BW     = max_u(E_bit, UW) + 2;
    localparam int unsigned BIAS_L = bias_of(E_bit);
    localparam int unsigned EMAX_L = e_max_of(E_bit);

    logic advance_c;

    logic             v0_d, v0_q, s0_d, s0_q;
    logic [I_bit-1:0] mag0_d, mag0_q;

    logic [LZW-1:0]   lz_c;
    logic             v1_d, v1_q, s1_d, s1_q;
    logic [I_bit-1:0] norm1_d, norm1_q;
    logic [UW-1:0]    e_unb1_d, e_unb1_q;

    logic [XW-1:0]    ext_c;
    logic [F_bit-1:0] frac_c;
    logic [F_bit:0]   frac_sum_c;
    logic [BW-1:0]    bexp_c;
    logic             guard_c, sticky_c, inc_c, zero_c, ovf_c;

    logic             out_valid_d, out_valid_q;
    logic [FW-1:0]    float_d, float_q;
    logic             inexact_d, inexact_q;
    logic             overflow_d, overflow_q;

    assign advance_c = ~out_valid_q | out_ready;
    assign in_ready  = advance_c;
    assign out_valid = out_valid_q;
    assign float_out = float_q;
    assign inexact   = inexact_q;
    assign overflow  = overflow_q;

    // S0: sign and magnitude; the most negative value maps to 2^(I_bit-1) exactly.
    always_comb begin
        v0_d   = in_valid;
        s0_d   = in_signed & int_in[I_bit-1];
        mag0_d = s0_d ? (~int_in + I_bit'(1)) : int_in;
    end

    lzc_prio #(.W(I_bit)) u_lzc (
        .d    (mag0_q),
        .lz_c (lz_c)
    );

    // S1: normalise; e_unb is meaningless for a zero magnitude and ignored downstream.
    always_comb begin
        v1_d     = v0_q;
        s1_d     = s0_q;
        norm1_d  = mag0_q << lz_c;
        e_unb1_d = UW'(32'(I_bit - 1) - 32'(lz_c));
    end

    // S2: round to nearest even, then pack or saturate to infinity.
    always_comb begin
        ext_c      = {norm1_q[I_bit-2:0], {(F_bit + 2){1'b0}}};
        frac_c     = ext_c[XW-1 -: F_bit];
        guard_c    = ext_c[XW-1-F_bit];
        sticky_c   = |ext_c[XW-2-F_bit:0];
        inc_c      = guard_c & (sticky_c | frac_c[0]);
        frac_sum_c = {1'b0, frac_c} + (F_bit + 1)'(inc_c);
        bexp_c     = BW'(e_unb1_q) + BW'(BIAS_L) + BW'(frac_sum_c[F_bit]);
        ovf_c      = bexp_c >= BW'(EMAX_L);
        zero_c     = ~norm1_q[I_bit-1];

        out_valid_d = v1_q;
        float_d     = '0;
        inexact_d   = 1'b0;
        overflow_d  = 1'b0;
        if (zero_c) begin
            float_d = '0;
        end else if (ovf_c) begin
            float_d    = {s1_q, E_bit'(EMAX_L), {F_bit{1'b0}}};
            inexact_d  = 1'b1;
            overflow_d = 1'b1;
        end else begin
            float_d   = {s1_q, bexp_c[E_bit-1:0], frac_sum_c[F_bit-1:0]};
            inexact_d = guard_c | sticky_c;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v0_q        <= 1'b0;
            s0_q        <= 1'b0;
            mag0_q      <= '0;
            v1_q        <= 1'b0;
            s1_q        <= 1'b0;
            norm1_q     <= '0;
            e_unb1_q    <= '0;
            out_valid_q <= 1'b0;
            float_q     <= '0;
            inexact_q   <= 1'b0;
            overflow_q  <= 1'b0;
        end else if (advance_c) begin
            v0_q        <= v0_d;
            s0_q        <= s0_d;
            mag0_q      <= mag0_d;
            v1_q        <= v1_d;
            s1_q        <= s1_d;
            norm1_q     <= norm1_d;
            e_unb1_q    <= e_unb1_d;
            out_valid_q <= out_valid_d;
            float_q     <= float_d;
            inexact_q   <= inexact_d;
            overflow_q  <= overflow_d;
        end
    end

endmodule

// File: tb/tb_int_to_float.sv
// Bench for int_to_float: default single-precision instance plus a half-precision instance
// for overflow cases, checked against an arithmetic reference model.
module tb_int_to_float;

    typedef struct packed {
        logic [31:0] f;
        logic        inex;
        logic        ovf;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] int_in = '0;
    logic        in_signed = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] float_out;
    logic        inexact;
    logic        overflow;

    logic        in_valid_h = 1'b0;
    logic        in_ready_h;
    logic [31:0] int_in_h = '0;
    logic        in_signed_h = 1'b0;
    logic        out_valid_h;
    logic        out_ready_h = 1'b1;
    logic [15:0] float_out_h;
    logic        inexact_h;
    logic        overflow_h;

    int   n_checks = 0;
    int   n_pass   = 0;
    int   mode     = 0;
    int   ph       = 0;
    exp_t q[$];

    always #5 clk = ~clk;

    int_to_float dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .int_in    (int_in),
        .in_signed (in_signed),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .float_out (float_out),
        .inexact   (inexact),
        .overflow  (overflow)
    );

    int_to_float #(.E_bit(5), .F_bit(10), .I_bit(32)) dut_h (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid_h),
        .in_ready  (in_ready_h),
        .int_in    (int_in_h),
        .in_signed (in_signed_h),
        .out_valid (out_valid_h),
        .out_ready (out_ready_h),
        .float_out (float_out_h),
        .inexact   (inexact_h),
        .overflow  (overflow_h)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    function automatic exp_t mk(input logic [31:0] f, input logic inex, input logic ovf);
        exp_t r;
        r.f = f; r.inex = inex; r.ovf = ovf;
        return r;
    endfunction

    // Reference: exact integer value, scaled to F+1 significant bits, nearest-even rounding.
    function automatic exp_t ref_conv(input logic [31:0] x, input bit sgn, input int E, input int F);
        exp_t   r;
        longint mag, qv, rem, half;
        int     e, sh, bexp;
        bit     neg, inex;
        r    = '0;
        neg  = sgn && x[31];
        mag  = {32'd0, x};
        if (neg) mag = (longint'(1) << 32) - mag;
        if (mag == 0) return r;
        e = 0;
        while ((mag >> (e + 1)) != 0) e++;
        inex = 1'b0;
        if (e <= F) begin
            qv = mag << (F - e);
        end else begin
            sh   = e - F;
            qv   = mag >> sh;
            rem  = mag - (qv << sh);
            half = longint'(1) << (sh - 1);
            inex = (rem != 0);
            if (rem > half || (rem == half && qv[0])) qv++;
        end
        if (qv == (longint'(1) << (F + 1))) begin
            qv = qv >> 1;
            e++;
        end
        bexp = e + (1 << (E - 1)) - 1;
        if (bexp >= (1 << E) - 1) begin
            r.f    = (32'(neg) << (E + F)) | (32'((1 << E) - 1) << F);
            r.inex = 1'b1;
            r.ovf  = 1'b1;
        end else begin
            r.f    = (32'(neg) << (E + F)) | (32'(bexp) << F) | 32'(qv - (longint'(1) << F));
            r.inex = inex;
        end
        return r;
    endfunction

    // One clock, then update the consumer's ready according to the current mode.
    task automatic tick();
        @(posedge clk);
        #1;
        case (mode)
            1: begin
                out_ready = ((ph % 4) == 0) || ((ph % 4) == 3);
                ph++;
            end
            2:       out_ready = 1'($urandom_range(0, 1));
            default: out_ready = 1'b1;
        endcase
    endtask

    task automatic send(input logic [31:0] x, input bit sgn, input exp_t e);
        int w;
        w = 0;
        in_valid  = 1'b1;
        int_in    = x;
        in_signed = sgn;
        forever begin
            @(negedge clk);
            if (in_ready) begin
                q.push_back(e);
                tick();
                break;
            end
            tick();
            w++;
            if (w > 50) begin
                chk("in_ready_timeout", 32'd0, 32'd1);
                break;
            end
        end
    endtask

    task automatic lat_test(input logic [31:0] x, input bit sgn, input exp_t e, input string tag);
        int lat;
        send(x, sgn, e);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 10) begin
            tick();
            lat++;
        end
        chk({tag, "_latency"}, 32'(lat), 32'd3);
        repeat (2) tick();
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q.size() != 0) && n < 200) begin
            tick();
            n++;
        end
        chk("drain_empty", 32'(q.size()), 32'd0);
        repeat (3) tick();
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_float_out"}, float_out, 32'd0);
        chk({tag, "_flags"}, {30'd0, inexact, overflow}, 32'd0);
    endtask

    task automatic send_h(input logic [31:0] x, input bit sgn, input exp_t e, input string tag);
        int n;
        in_valid_h  = 1'b1;
        int_in_h    = x;
        in_signed_h = sgn;
        tick();
        in_valid_h = 1'b0;
        n = 1;
        while (!out_valid_h && n < 10) begin
            tick();
            n++;
        end
        chk({tag, "_latency"}, 32'(n), 32'd3);
        chk({tag, "_float"}, {16'd0, float_out_h}, e.f);
        chk({tag, "_inexact"}, 32'(inexact_h), 32'(e.inex));
        chk({tag, "_overflow"}, 32'(overflow_h), 32'(e.ovf));
        tick();
    endtask

    // Output monitor: scoreboard order, hold-while-stalled and ready relation.
    exp_t        e_mon;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_f;
    logic [1:0]  prev_fl;
    always @(negedge clk) begin
        if (rst !== 1'b0) begin
            prev_stall = 1'b0;
        end else begin
            chk("in_ready_rel", 32'(in_ready), 32'(!out_valid || out_ready));
            if (prev_stall) begin
                chk("hold_float", float_out, prev_f);
                chk("hold_flags", {30'd0, inexact, overflow}, {30'd0, prev_fl});
            end
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    chk("unexpected_output", 32'd1, 32'd0);
                end else begin
                    e_mon = q.pop_front();
                    chk("float_out", float_out, e_mon.f);
                    chk("inexact", 32'(inexact), 32'(e_mon.inex));
                    chk("overflow", 32'(overflow), 32'(e_mon.ovf));
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_f     = float_out;
            prev_fl    = {inexact, overflow};
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] x;
        bit          sgn;

        repeat (3) tick();
        rst = 1'b0;
        check_reset_state("reset");
        chk("reset_in_ready", 32'(in_ready), 32'd1);
        chk("reset_out_valid_h", 32'(out_valid_h), 32'd0);

        lat_test(32'd1, 1'b0, mk(32'h3F80_0000, 1'b0, 1'b0), "one_u");
        lat_test(32'hFFFF_FFFF, 1'b1, mk(32'hBF80_0000, 1'b0, 1'b0), "neg_one_s");
        lat_test(32'd0, 1'b1, mk(32'h0000_0000, 1'b0, 1'b0), "zero");

        send(32'd16777217, 1'b0, mk(32'h4B80_0000, 1'b1, 1'b0));
        send(32'd16777219, 1'b0, mk(32'h4B80_0002, 1'b1, 1'b0));
        send(32'h8000_0000, 1'b1, mk(32'hCF00_0000, 1'b0, 1'b0));
        send(32'hFFFF_FFFF, 1'b0, mk(32'h4F80_0000, 1'b1, 1'b0));
        send(32'h8000_0000, 1'b0, mk(32'h4F00_0000, 1'b0, 1'b0));
        in_valid = 1'b0;
        drain();

        // Backpressure: ready pattern 1,0,0,1 with a continuous input stream.
        mode = 1;
        ph   = 0;
        for (int i = 1; i <= 8; i++) send(32'(i), 1'b0, ref_conv(32'(i), 1'b0, 8, 23));
        in_valid = 1'b0;
        drain();
        mode = 0;
        tick();

        // Reset with three conversions in flight, then a fresh conversion.
        send(32'd100, 1'b0, ref_conv(32'd100, 1'b0, 8, 23));
        send(32'd200, 1'b0, ref_conv(32'd200, 1'b0, 8, 23));
        send(32'd300, 1'b0, ref_conv(32'd300, 1'b0, 8, 23));
        rst      = 1'b1;
        in_valid = 1'b0;
        q.delete();
        tick();
        rst = 1'b0;
        check_reset_state("midreset");
        lat_test(32'd12345, 1'b0, ref_conv(32'd12345, 1'b0, 8, 23), "after_reset");

        // Random stream with random consumer stalls and input bubbles.
        mode = 2;
        repeat (300) begin
            if ($urandom_range(0, 4) == 0) begin
                in_valid = 1'b0;
                tick();
            end else begin
                case ($urandom_range(0, 4))
                    0:       x = $urandom;
                    1:       x = $urandom_range(0, 255);
                    2:       x = 32'd1 << $urandom_range(0, 31);
                    3:       x = 32'h8000_0000 | 32'($urandom_range(0, 3));
                    default: x = 32'h0100_0000 + 32'($urandom_range(0, 7));
                endcase
                sgn = 1'($urandom_range(0, 1));
                send(x, sgn, ref_conv(x, sgn, 8, 23));
            end
        end
        in_valid = 1'b0;
        mode = 0;
        drain();

        // Half-precision instance: exact max, overflow by rounding, negative overflow.
        send_h(32'd1, 1'b0, mk(32'h0000_3C00, 1'b0, 1'b0), "h_one");
        send_h(32'd65504, 1'b0, mk(32'h0000_7BFF, 1'b0, 1'b0), "h_max");
        send_h(32'd65520, 1'b0, mk(32'h0000_7C00, 1'b1, 1'b1), "h_ovf");
        send_h(32'hFFFF_0010, 1'b1, mk(32'h0000_FC00, 1'b1, 1'b1), "h_neg_ovf");
        repeat (20) begin
            sgn = 1'($urandom_range(0, 1));
            x   = 32'($urandom_range(0, 131071));
            if (sgn) x = 32'd0 - x;
            send_h(x, sgn, ref_conv(x, sgn, 5, 10), "h_rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
